mac_seq_ctrl: RTL and testbench

Sequencer that drives one MAC processing element through a complete dot product.
- On a start command it fetches K operand pairs from the A-row and B-column operand buffers.
- It presents each pair to the MAC with the waiting/ready handshake, then signals finished on both streams.
- It captures the MAC result and reports done.
- It sits between the operand buffers / top-level scheduler and each MAC, and is the unit later replicated per array edge.

---
 rtl/mac_pkg.sv | 25 ++
 rtl/mac_seq_addr_gen.sv | 43 ++++
 rtl/mac_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types for the MAC array: sequencer state encoding and the
// waiting/finished/ready handshake bundle used between sequencers and MACs.
package mac_pkg;

  localparam int MAC_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LOAD    = 3'd2,
    S_PRESENT = 3'd3,
    S_FINISH  = 3'd4,
    S_DONE    = 3'd5
  } seq_state_t;

  // Handshake: a transfer happens on a cycle where waiting and ready are both
  // high on the A and B streams together. finished marks end-of-stream and is
  // acknowledged the same way; waiting and finished are never high together.
  typedef struct packed {
    logic waiting;
    logic finished;
    logic ready;
  } mac_hs_t;

endpackage

// File: rtl/mac_seq_addr_gen.sv
// Pair index counter and A/B operand buffer address accumulators.
// B advances by a stride add each pair instead of idx*stride multiplication.
module mac_seq_addr_gen #(
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] a_base,
  input  logic [ADDR_WIDTH-1:0] b_base,
  input  logic [ADDR_WIDTH-1:0] b_stride,
  output logic [LEN_WIDTH-1:0]  idx,
  output logic [ADDR_WIDTH-1:0] a_addr,
  output logic [ADDR_WIDTH-1:0] b_addr
);

  localparam logic [LEN_WIDTH-1:0]  IDX_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  logic [ADDR_WIDTH-1:0] stride_q;

  // Address sums wrap modulo 2^ADDR_WIDTH by construction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      a_addr   <= '0;
      b_addr   <= '0;
      stride_q <= '0;
    end else if (load) begin
      idx      <= '0;
      a_addr   <= a_base;
      b_addr   <= b_base;
      stride_q <= b_stride;
    end else if (step) begin
      idx      <= idx + IDX_ONE;
      a_addr   <= a_addr + ADDR_ONE;
      b_addr   <= b_addr + stride_q;
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: fetches K operand pairs, streams them to one MAC,
// closes both streams with finished, then captures the MAC result.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = MAC_DATA_WIDTH,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  k_len,
  input  logic [ADDR_WIDTH-1:0] a_base,
  input  logic [ADDR_WIDTH-1:0] b_base,
  input  logic [ADDR_WIDTH-1:0] b_stride,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] a_addr,
  output logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] a_rdata,
  input  logic [DATA_WIDTH-1:0] b_rdata,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  output logic                  mac_a_waiting,
  output logic                  mac_b_waiting,
  output logic                  mac_a_finished,
  output logic                  mac_b_finished,
  input  logic                  mac_a_ready,
  input  logic                  mac_b_ready,
  input  logic [DATA_WIDTH-1:0] mac_c,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done,
  output logic                  busy,
  output logic                  error,
  output logic [2:0]            state
);

  localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
  localparam logic [WDOG_W-1:0] WDOG_ONE  = 1;
  localparam logic [LEN_WIDTH:0] IDX_ONE  = 1;

  seq_state_t state_q, state_d;
  mac_hs_t    a_hs, b_hs;

  logic                 accept;
  logic                 step;
  logic                 in_hs;
  logic                 both_ready;
  logic                 timeout;
  logic                 last_pair;
  logic [LEN_WIDTH-1:0] k_q;
  logic [LEN_WIDTH-1:0] idx;
  logic [WDOG_W-1:0]    wdog;

  mac_seq_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     (step),
    .a_base   (a_base),
    .b_base   (b_base),
    .b_stride (b_stride),
    .idx      (idx),
    .a_addr   (a_addr),
    .b_addr   (b_addr)
  );

  // One extra bit so k_len = 2^LEN_WIDTH-1 compares without idx wrapping.
  assign last_pair = (({1'b0, idx} + IDX_ONE) == {1'b0, k_q});
  assign accept    = (state_q == S_IDLE) & start;
  assign timeout   = in_hs & ~both_ready & (wdog == WDOG_LAST);

  always_comb begin
    state_d      = state_q;
    a_hs         = '0;
    b_hs         = '0;
    a_hs.ready   = mac_a_ready;
    b_hs.ready   = mac_b_ready;
    both_ready   = a_hs.ready & b_hs.ready;
    in_hs        = 1'b0;
    rd_en        = 1'b0;
    step         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (k_len != '0) ? S_FETCH : S_FINISH;
      end
      S_FETCH: begin
        rd_en   = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: state_d = S_PRESENT;
      S_PRESENT: begin
        in_hs        = 1'b1;
        a_hs.waiting = 1'b1;
        b_hs.waiting = 1'b1;
        if (both_ready) begin
          step    = 1'b1;
          state_d = last_pair ? S_FINISH : S_FETCH;
        end else if (wdog == WDOG_LAST) begin
          state_d = S_IDLE;
        end
      end
      S_FINISH: begin
        in_hs         = 1'b1;
        a_hs.finished = 1'b1;
        b_hs.finished = 1'b1;
        if (both_ready) state_d = S_DONE;
        else if (wdog == WDOG_LAST) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Watchdog counts handshake cycles without acknowledgement; it restarts on
  // every transfer so each pair and the final finished get a full budget.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      wdog    <= '0;
      error   <= 1'b0;
      mac_a   <= '0;
      mac_b   <= '0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        k_q   <= k_len;
        wdog  <= '0;
        error <= 1'b0;
      end else if (timeout) begin
        wdog  <= '0;
        error <= 1'b1;
      end else if (in_hs && both_ready) begin
        wdog <= '0;
      end else if (in_hs) begin
        wdog <= wdog + WDOG_ONE;
      end
      if (state_q == S_LOAD) begin
        mac_a <= a_rdata;
        mac_b <= b_rdata;
      end
      if (state_q == S_FINISH && both_ready) result <= mac_c;
    end
  end

  assign mac_a_waiting  = a_hs.waiting;
  assign mac_b_waiting  = b_hs.waiting;
  assign mac_a_finished = a_hs.finished;
  assign mac_b_finished = b_hs.finished;
  assign done           = (state_q == S_DONE);
  assign busy           = (state_q != S_IDLE);
  assign state          = state_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: operand buffer and MAC models around the sequencer,
// with expected addresses, operand pairs and dot products computed from memory.
module tb_mac_seq_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int LW = 8;
  localparam int TO = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] k_len;
  logic [AW-1:0] a_base, b_base, b_stride;
  logic          rd_en;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [DW-1:0] mac_a, mac_b;
  logic          mac_a_waiting, mac_b_waiting;
  logic          mac_a_finished, mac_b_finished;
  logic          mac_a_ready, mac_b_ready;
  logic [DW-1:0] mac_c;
  logic [DW-1:0] result;
  logic          done, busy, error;
  logic [2:0]    state;

  logic [DW-1:0] a_mem [256];
  logic [DW-1:0] b_mem [256];
  logic [AW-1:0] ea_q [$];
  logic [AW-1:0] eb_q [$];
  logic [2*DW-1:0] exp_q [$];
  logic [DW-1:0] acc;

  int n_vec = 0;
  int n_err = 0;

  mac_seq_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW),
    .TIMEOUT    (TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .k_len          (k_len),
    .a_base         (a_base),
    .b_base         (b_base),
    .b_stride       (b_stride),
    .rd_en          (rd_en),
    .a_addr         (a_addr),
    .b_addr         (b_addr),
    .a_rdata        (a_rdata),
    .b_rdata        (b_rdata),
    .mac_a          (mac_a),
    .mac_b          (mac_b),
    .mac_a_waiting  (mac_a_waiting),
    .mac_b_waiting  (mac_b_waiting),
    .mac_a_finished (mac_a_finished),
    .mac_b_finished (mac_b_finished),
    .mac_a_ready    (mac_a_ready),
    .mac_b_ready    (mac_b_ready),
    .mac_c          (mac_c),
    .result         (result),
    .done           (done),
    .busy           (busy),
    .error          (error),
    .state          (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Operand buffers: data appears one cycle after rd_en, garbage otherwise.
  always @(posedge clk) begin
    if (rd_en) begin
      a_rdata <= a_mem[a_addr];
      b_rdata <= b_mem[b_addr];
    end else begin
      a_rdata <= $urandom;
      b_rdata <= $urandom;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_state"}, 64'(state), 64'(0));
    chk({tag, "_rd_en"}, 64'(rd_en), 64'(0));
    chk({tag, "_a_addr"}, 64'(a_addr), 64'(0));
    chk({tag, "_b_addr"}, 64'(b_addr), 64'(0));
    chk({tag, "_mac_a"}, 64'(mac_a), 64'(0));
    chk({tag, "_mac_b"}, 64'(mac_b), 64'(0));
    chk({tag, "_hs"}, 64'({mac_a_waiting, mac_b_waiting, mac_a_finished, mac_b_finished}), 64'(0));
    chk({tag, "_result"}, 64'(result), 64'(0));
    chk({tag, "_flags"}, 64'({done, busy, error}), 64'(0));
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) begin
      a_mem[i] = $urandom;
      b_mem[i] = $urandom;
    end
  endtask

  task automatic run_job(input int k, input int ab, input int bb, input int bs,
                         input int fixed_stall, input bit rand_stall,
                         input bit never_ready, input bit poke_busy,
                         input logic [DW-1:0] bias);
    logic [DW-1:0]   exp_sum;
    logic [AW-1:0]   aa, ba;
    logic [2*DW-1:0] pair;
    logic [DW-1:0]   hold_a, hold_b;
    int cyc, n_done, n_wait, n_xfer, n_rd, run, budget;
    bit prev_wait, low;
    exp_sum = bias;
    ea_q.delete(); eb_q.delete(); exp_q.delete();
    for (int i = 0; i < k; i++) begin
      aa = AW'((ab + i) % 256);
      ba = AW'((bb + i * bs) % 256);
      ea_q.push_back(aa);
      eb_q.push_back(ba);
      exp_q.push_back({a_mem[aa], b_mem[ba]});
      exp_sum = exp_sum + a_mem[aa] * b_mem[ba];
    end
    @(negedge clk);
    start = 1'b1; k_len = LW'(k); a_base = AW'(ab); b_base = AW'(bb); b_stride = AW'(bs);
    acc = bias; mac_c = bias;
    @(negedge clk);
    start = 1'b0;
    k_len = LW'($urandom); a_base = AW'($urandom); b_base = AW'($urandom); b_stride = AW'($urandom);
    chk("busy_rise", 64'(busy), 64'(1));
    chk("err_clr", 64'(error), 64'(0));
    cyc = 0; n_done = 0; n_wait = 0; n_xfer = 0; n_rd = 0; run = 0; prev_wait = 1'b0;
    hold_a = '0; hold_b = '0;
    budget = 3 * k + 2 + (k + 1) * TO + 8;
    while (cyc < budget) begin
      if (rd_en) begin
        n_rd++;
        if (ea_q.size() > 0) begin
          chk("a_addr", 64'(a_addr), 64'(ea_q.pop_front()));
          chk("b_addr", 64'(b_addr), 64'(eb_q.pop_front()));
        end
      end
      if (mac_a_waiting) begin
        n_wait++;
        if (prev_wait) begin
          chk("hold_a", 64'(mac_a), 64'(hold_a));
          chk("hold_b", 64'(mac_b), 64'(hold_b));
        end
        hold_a = mac_a; hold_b = mac_b;
      end
      prev_wait = mac_a_waiting;
      chk("wait_pair", 64'(mac_b_waiting), 64'(mac_a_waiting));
      chk("fin_pair", 64'(mac_b_finished), 64'(mac_a_finished));
      chk("wait_fin_excl", 64'(mac_a_waiting & mac_a_finished), 64'(0));
      if (done) begin
        n_done++;
        chk("result", 64'(result), 64'(exp_sum));
        break;
      end
      if (!busy) break;
      if (mac_a_waiting | mac_a_finished) begin
        low = never_ready || run < fixed_stall ||
              (rand_stall && run < TO - 2 && $urandom_range(0, 2) == 0);
        if (low) begin
          case ($urandom_range(0, 2))
            0:       begin mac_a_ready = 1'b0; mac_b_ready = 1'b0; end
            1:       begin mac_a_ready = 1'b1; mac_b_ready = 1'b0; end
            default: begin mac_a_ready = 1'b0; mac_b_ready = 1'b1; end
          endcase
          if (never_ready) begin mac_a_ready = 1'b0; mac_b_ready = 1'b0; end
          run++;
        end else begin
          mac_a_ready = 1'b1; mac_b_ready = 1'b1;
          run = 0;
          if (mac_a_waiting) begin
            n_xfer++;
            if (exp_q.size() > 0) begin
              pair = exp_q.pop_front();
              chk("mac_a", 64'(mac_a), 64'(pair[2*DW-1:DW]));
              chk("mac_b", 64'(mac_b), 64'(pair[DW-1:0]));
            end
            acc = acc + mac_a * mac_b;
            mac_c = acc;
          end
        end
      end else begin
        mac_a_ready = 1'($urandom_range(0, 1));
        mac_b_ready = 1'($urandom_range(0, 1));
      end
      if (poke_busy) start = (cyc == 1);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (never_ready) begin
      chk("to_busy", 64'(busy), 64'(0));
      chk("to_error", 64'(error), 64'(1));
      chk("to_wait_drop", 64'(mac_a_waiting), 64'(0));
      chk("to_done", 64'(n_done), 64'(0));
      chk("to_wait_cycles", 64'(n_wait), 64'(TO));
    end else begin
      chk("done_cnt", 64'(n_done), 64'(1));
      chk("xfer_cnt", 64'(n_xfer), 64'(k));
      chk("rd_cnt", 64'(n_rd), 64'(k));
      chk("no_error", 64'(error), 64'(0));
      if (!rand_stall) chk("latency", 64'(cyc), 64'(3 * k + 1 + fixed_stall * (k + 1)));
      // start raised during the DONE cycle only; it must not launch a job
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("done_1cyc", 64'(done), 64'(0));
      chk("busy_fall", 64'(busy), 64'(0));
      @(negedge clk);
      chk("no_restart", 64'(busy), 64'(0));
    end
  endtask

  task automatic reset_mid_present();
    int i;
    @(negedge clk);
    start = 1'b1; k_len = 8'd4; a_base = 8'd3; b_base = 8'd9; b_stride = 8'd2;
    @(negedge clk);
    start = 1'b0;
    mac_a_ready = 1'b0; mac_b_ready = 1'b0;
    i = 0;
    while (i < 10 && !mac_a_waiting) begin
      @(negedge clk);
      i++;
    end
    chk("rst_reach_present", 64'(mac_a_waiting), 64'(1));
    start = 1'b1; k_len = 8'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("mid_rst");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_busy", 64'({busy, done}), 64'(0));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; k_len = '0; a_base = '0; b_base = '0; b_stride = '0;
    mac_a_ready = 1'b0; mac_b_ready = 1'b0; mac_c = '0; acc = '0;
    fill_mem();
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;

    // basic 3-pair dot product: 1*4 + 2*5 + 3*6
    for (int i = 0; i < 3; i++) begin
      a_mem[16 + i] = DW'(i + 1);
      b_mem[32 + i] = DW'(i + 4);
    end
    run_job(3, 16, 32, 1, 0, 1'b0, 1'b0, 1'b0, '0);
    chk("t1_result", 64'(result), 64'(32));

    // B address wrap: 250, 254, 2
    run_job(3, 5, 250, 4, 0, 1'b0, 1'b0, 1'b0, DW'($urandom));
    // long stall below the watchdog limit
    run_job(2, 40, 60, 3, 10, 1'b0, 1'b0, 1'b0, DW'($urandom));
    // watchdog timeout, then a normal job that clears error
    run_job(2, 0, 0, 1, 0, 1'b0, 1'b1, 1'b0, '0);
    run_job(1, 70, 80, 5, 0, 1'b0, 1'b0, 1'b0, DW'($urandom));
    // empty dot product returns mac_c directly
    run_job(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, DW'($urandom));
    // start while busy is ignored
    run_job(2, 100, 120, 7, 0, 1'b0, 1'b0, 1'b1, DW'($urandom));
    reset_mid_present();
    // maximum length
    run_job(255, 0, 7, 3, 0, 1'b0, 1'b0, 1'b0, DW'($urandom));

    for (int j = 0; j < 25; j++) begin
      fill_mem();
      run_job($urandom_range(0, 6), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), 0, 1'b1, 1'b0, 1'b0, DW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
